// File: rtl/clk_div_monitor_pkg.sv
// rtl/clk_div_monitor_pkg.sv - shared states and divider constants for the divided-clock monitor
package clk_div_monitor_pkg;

    localparam int DIV_N            = 15;
    localparam int EXPECTED_DEFAULT = 1 << DIV_N;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t MEASURE = 2'd1;
    localparam state_t LOCKED  = 2'd2;
    localparam state_t LOST    = 2'd3;

endpackage

// File: rtl/clk_div_monitor_sync_edge_detect.sv
// rtl/clk_div_monitor_sync_edge_detect.sv - synchroniser plus registered rise/fall strobes for a slow clock
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise_det,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev;
    logic                   fall_det;

    assign s        = sync_q[SYNC_STAGES-1];
    // rise_det is the combinational edge; it lets the consumer act in the same cycle rise_pulse is set
    assign rise_det = s & ~prev;
    assign fall_det = ~s & prev;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q     <= '0;
            prev       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev       <= s;
            rise_pulse <= rise_det;
            fall_pulse <= fall_det;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divided-clock monitor: edge strobes, period measurement, lock and loss detection
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EXPECTED    = EXPECTED_DEFAULT,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 65536
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP_V   = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_COUNT - 1);

    logic             rise_det;
    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  match_cnt, next_match;
    logic [CNT_W:0]   period, diff;
    logic             match, report;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .rise_det   (rise_det),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // One extra bit so the absolute difference never wraps
    assign period = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign diff   = (period >= EXP_V) ? (period - EXP_V) : (EXP_V - period);
    assign match  = (diff <= TOL_V);

    always_comb begin
        next_state = state;
        next_match = match_cnt;
        report     = 1'b0;
        if (rise_det) begin
            case (state)
                MEASURE: begin
                    report = 1'b1;
                    if (match) begin
                        next_match = match_cnt + MC_W'(1);
                        if (match_cnt == MC_LAST) next_state = LOCKED;
                    end else begin
                        next_match = '0;
                    end
                end
                LOCKED: begin
                    report = 1'b1;
                    if (!match) begin
                        next_state = MEASURE;
                        next_match = '0;
                    end
                end
                default: begin
                    // IDLE and LOST: start point of this period is unknown, so only restart
                    next_state = MEASURE;
                    next_match = '0;
                end
            endcase
        end else if (cnt >= CNT_THR) begin
            next_state = LOST;
            next_match = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= next_state;
            match_cnt    <= next_match;
            cnt          <= rise_det ? '0 : ((cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1));
            period_valid <= report;
            if (report) period_out <= period[CNT_W-1:0];
            locked       <= (next_state == LOCKED);
            timeout      <= (next_state == LOST);
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;

    localparam int CNT_W = 24;
    localparam int TO    = 64;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             rise_pulse, fall_pulse, period_valid, locked, timeout;
    logic [CNT_W-1:0] period_out;

    clk_div_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .EXPECTED(16), .TOL(1), .LOCK_COUNT(3), .TIMEOUT(TO)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .sig_in       (sig_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        bit pv;
        int per;
        bit lk;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0, fails = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    int   m_state = 0;
    int   m_mc = 0;
    int   m_last = 0;
    int   last_rp_cyc = 0;
    int   fall_delta = -1;
    int   exp_last_per = 0;
    int   n_to = 0;
    bit   to_prev = 0;

    always @(posedge clk_in) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model in the sig_in domain: 0 IDLE, 1 MEASURE, 2 LOCKED
    task automatic model_rise();
        int  gap;
        bit  pv;
        bit  m;
        gap    = cyc - m_last;
        m_last = cyc;
        pv     = 0;
        if (m_state == 0 || gap > TO) begin
            m_state = 1;
            m_mc    = 0;
        end else begin
            pv = 1;
            m  = (gap >= 15 && gap <= 17);
            if (m_state == 1) begin
                if (m) begin
                    m_mc++;
                    if (m_mc == 3) m_state = 2;
                end else begin
                    m_mc = 0;
                end
            end else if (!m) begin
                m_state = 1;
                m_mc    = 0;
            end
        end
        sbq.push_back('{cyc + 3, pv, gap, m_state == 2});
    endtask

    task automatic drive_period(input int hi, input int lo);
        sig_in = 1'b1;
        model_rise();
        repeat (hi) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_rise"}, rise_pulse, 0);
        check_eq({tag, "_fall"}, fall_pulse, 0);
        check_eq({tag, "_per"}, period_out, 0);
        check_eq({tag, "_pv"}, period_valid, 0);
        check_eq({tag, "_lk"}, locked, 0);
        check_eq({tag, "_to"}, timeout, 0);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (mon_en) begin
            check_eq("lk_to_excl", locked & timeout, 0);
            if (rise_pulse) begin
                last_rp_cyc = cyc;
                check_eq("rise_queued", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check_eq("rise_lat", cyc, e.cyc);
                    check_eq("pv", period_valid, e.pv);
                    if (e.pv) begin
                        check_eq("period", period_out, e.per);
                        exp_last_per = e.per;
                    end
                    check_eq("locked", locked, e.lk);
                    check_eq("to_at_rise", timeout, 0);
                end
            end else begin
                check_eq("pv_no_rise", period_valid, 0);
            end
            if (fall_pulse) fall_delta = cyc - last_rp_cyc;
            if (timeout && !to_prev) begin
                n_to++;
                check_eq("to_lat", cyc - last_rp_cyc, TO);
                check_eq("to_locked", locked, 0);
                check_eq("to_per_held", period_out, exp_last_per);
            end
            to_prev = timeout;
        end
    end

    initial begin
        repeat (5000) @(posedge clk_in);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_cleared("rst0");
        rst    = 1'b0;
        mon_en = 1;
        @(negedge clk_in);

        // Acquire lock on period 16
        repeat (5) drive_period(8, 8);
        // One period of 20 breaks lock, then relock
        drive_period(10, 10);
        repeat (4) drive_period(8, 8);
        // Tolerance edges 15 and 17 hold, 18 breaks
        drive_period(8, 7);
        drive_period(9, 8);
        drive_period(9, 9);
        repeat (4) drive_period(8, 8);
        // Loss of the slow clock, then recovery
        drive_period(8, 100);
        repeat (4) drive_period(8, 8);

        // Reset mid-period while locked
        sig_in = 1'b1;
        model_rise();
        repeat (8) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (6) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        check_cleared("rst1");
        rst     = 1'b0;
        m_state = 0;
        m_mc    = 0;
        repeat (3) @(negedge clk_in);
        repeat (5) drive_period(8, 8);

        // Rising edge coincident with the timeout threshold, then fall lag
        drive_period(32, 32);
        drive_period(5, 11);
        check_eq("fall_lag", fall_delta, 5);
        drive_period(8, 8);
        sig_in = 1'b1;
        model_rise();
        repeat (10) @(negedge clk_in);

        check_eq("sb_drained", sbq.size(), 0);
        check_eq("n_timeouts", n_to, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
